// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and ordered reset release with 48/12 MHz enable strobes on the 96 MHz clock.
// Optional saturating lock-loss counter enabled by defining PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int SETTLE_CYCLES    = 9600,
  parameter int USB_DELAY_CYCLES = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       usb_reset,
  output logic       stb_48mhz,
  output logic       stb_12mhz,
  output logic       lock_lost,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    SYS_UP    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] USB_LAST    = 16'(USB_DELAY_CYCLES - 1);

  state_t      state_q, state_d;
  logic        lock_meta_q, lock_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  div_q, div_d;
  logic        sys_reset_q, sys_reset_d;
  logic        usb_reset_q, usb_reset_d;
  logic        stb_48_q, stb_48_d;
  logic        stb_12_q, stb_12_d;
  logic        lock_lost_q, lock_lost_d;
  logic        loss_event;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = 16'd0;
        if (lock_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SYS_UP;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SYS_UP: begin
        if (!lock_s_q) begin
          state_d    = WAIT_LOCK;
          cnt_d      = 16'd0;
          loss_event = 1'b1;
        end else if (cnt_q == USB_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d    = WAIT_LOCK;
          cnt_d      = 16'd0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = 16'd0;
      end
    endcase

    // Divider restarts at 0 on RUN entry so the first RUN cycle carries no strobe.
    div_d       = (state_q == RUN && state_d == RUN) ? div_q + 3'd1 : 3'd0;
    sys_reset_d = (state_d == WAIT_LOCK) || (state_d == SETTLE);
    usb_reset_d = (state_d != RUN);
    stb_48_d    = (state_d == RUN) && div_d[0];
    stb_12_d    = (state_d == RUN) && (div_d == 3'd7);
    lock_lost_d = lock_lost_q | loss_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      cnt_q       <= 16'd0;
      div_q       <= 3'd0;
      sys_reset_q <= 1'b1;
      usb_reset_q <= 1'b1;
      stb_48_q    <= 1'b0;
      stb_12_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      sys_reset_q <= sys_reset_d;
      usb_reset_q <= usb_reset_d;
      stb_48_q    <= stb_48_d;
      stb_12_q    <= stb_12_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event && loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) loss_cnt_q <= 8'd0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = 8'd0;
`endif

  assign sys_reset = sys_reset_q;
  assign usb_reset = usb_reset_q;
  assign stb_48mhz = stb_48_q;
  assign stb_12mhz = stb_12_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SETTLE_CYCLES=10, USB_DELAY_CYCLES=4.
module tb_pll_reset_sequencer;

  localparam int S = 10;
  localparam int U = 4;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int N_LOSS = 300;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int N_LOSS = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset, usb_reset, stb_48mhz, stb_12mhz, lock_lost;
  logic [7:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .SETTLE_CYCLES   (S),
    .USB_DELAY_CYCLES(U)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .sys_reset      (sys_reset),
    .usb_reset      (usb_reset),
    .stb_48mhz      (stb_48mhz),
    .stb_12mhz      (stb_12mhz),
    .lock_lost      (lock_lost),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL rst_sys got=%b exp=1", sys_reset); end
    checks++; if (usb_reset !== 1'b1) begin failures++; $display("FAIL rst_usb got=%b exp=1", usb_reset); end
    checks++; if (stb_48mhz !== 1'b0) begin failures++; $display("FAIL rst_stb48 got=%b exp=0", stb_48mhz); end
    checks++; if (stb_12mhz !== 1'b0) begin failures++; $display("FAIL rst_stb12 got=%b exp=0", stb_12mhz); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL rst_lost got=%b exp=0", lock_lost); end
    checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", lock_loss_count); end
  endtask

  // Drives lock high and checks release edges S+3 and S+U+3; ends in RUN cycle 0.
  task automatic lockin_seq(input string tag, input logic exp_lost);
    logic exp_sys, exp_usb;
    pll_locked = 1'b1;
    for (int e = 1; e <= S + U + 3; e++) begin
      tick();
      exp_sys = (e < S + 3);
      exp_usb = (e < S + U + 3);
      checks++; if (sys_reset !== exp_sys) begin failures++; $display("FAIL %s_sys edge=%0d got=%b exp=%b", tag, e, sys_reset, exp_sys); end
      checks++; if (usb_reset !== exp_usb) begin failures++; $display("FAIL %s_usb edge=%0d got=%b exp=%b", tag, e, usb_reset, exp_usb); end
      checks++; if (lock_lost !== exp_lost) begin failures++; $display("FAIL %s_lost edge=%0d got=%b exp=%b", tag, e, lock_lost, exp_lost); end
    end
  endtask

  task automatic test_strobes();
    int n48 = 0;
    int n12 = 0;
    logic e48, e12;
    for (int c = 0; c < 32; c++) begin
      e48 = (c % 2 == 1);
      e12 = (c % 8 == 7);
      checks++; if (stb_48mhz !== e48) begin failures++; $display("FAIL stb48 cycle=%0d got=%b exp=%b", c, stb_48mhz, e48); end
      checks++; if (stb_12mhz !== e12) begin failures++; $display("FAIL stb12 cycle=%0d got=%b exp=%b", c, stb_12mhz, e12); end
      if (stb_48mhz === 1'b1) n48++;
      if (stb_12mhz === 1'b1) n12++;
      tick();
    end
    checks++; if (n48 != 16) begin failures++; $display("FAIL stb48_count got=%0d exp=16", n48); end
    checks++; if (n12 != 4) begin failures++; $display("FAIL stb12_count got=%0d exp=4", n12); end
  endtask

  task automatic test_lock_drop();
    logic exp_hi;
    logic [7:0] exp_cnt;
    pll_locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      exp_hi = (e >= 3);
      checks++; if (sys_reset !== exp_hi) begin failures++; $display("FAIL drop_sys edge=%0d got=%b exp=%b", e, sys_reset, exp_hi); end
      checks++; if (usb_reset !== exp_hi) begin failures++; $display("FAIL drop_usb edge=%0d got=%b exp=%b", e, usb_reset, exp_hi); end
      checks++; if (lock_lost !== exp_hi) begin failures++; $display("FAIL drop_lost edge=%0d got=%b exp=%b", e, lock_lost, exp_hi); end
      checks++; if (stb_48mhz !== 1'b0 && e >= 3) begin failures++; $display("FAIL drop_stb48 edge=%0d got=%b exp=0", e, stb_48mhz); end
    end
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    checks++; if (lock_loss_count !== exp_cnt) begin failures++; $display("FAIL drop_cnt got=%0d exp=%0d", lock_loss_count, exp_cnt); end
  endtask

  task automatic test_reset_sys_up();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (S + 4) tick();
    checks++; if (sys_reset !== 1'b0 || usb_reset !== 1'b1) begin failures++; $display("FAIL sysup_state got=%b%b exp=01", sys_reset, usb_reset); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL sysup_rst_sys got=%b exp=1", sys_reset); end
    checks++; if (usb_reset !== 1'b1) begin failures++; $display("FAIL sysup_rst_usb got=%b exp=1", usb_reset); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL sysup_rst_lost got=%b exp=0", lock_lost); end
    checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL sysup_rst_cnt got=%0d exp=0", lock_loss_count); end
    checks++; if (stb_48mhz !== 1'b0 || stb_12mhz !== 1'b0) begin failures++; $display("FAIL sysup_rst_stb got=%b%b exp=00", stb_48mhz, stb_12mhz); end
  endtask

  // One-cycle dropout at SETTLE cnt=5 delays release by the restart.
  task automatic test_settle_glitch();
    logic exp_sys;
    apply_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      tick();
      exp_sys = (e < 22);
      checks++; if (sys_reset !== exp_sys) begin failures++; $display("FAIL glitch_sys edge=%0d got=%b exp=%b", e, sys_reset, exp_sys); end
      checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL glitch_lost edge=%0d got=%b exp=0", e, lock_lost); end
      if (e == 8) pll_locked = 1'b0;
      if (e == 9) pll_locked = 1'b1;
    end
  endtask

  task automatic test_terminal_drop();
    apply_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL term_sys edge=%0d got=%b exp=1", e, sys_reset); end
      checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL term_lost edge=%0d got=%b exp=0", e, lock_lost); end
      if (e == 10) pll_locked = 1'b0;
    end
  endtask

  task automatic test_reset_with_drop();
    apply_reset();
    lockin_seq("rwd", 1'b0);
    pll_locked = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL rwd_lost step=%0d got=%b exp=0", e, lock_lost); end
      checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL rwd_cnt step=%0d got=%0d exp=0", e, lock_loss_count); end
      checks++; if (sys_reset !== 1'b1 || usb_reset !== 1'b1) begin failures++; $display("FAIL rwd_rst step=%0d got=%b%b exp=11", e, sys_reset, usb_reset); end
      tick();
    end
  endtask

  task automatic test_loss_count();
    logic [7:0] exp_cnt;
    apply_reset();
    for (int i = 0; i < N_LOSS; i++) begin
      pll_locked = 1'b1;
      repeat (S + U + 3) tick();
      pll_locked = 1'b0;
      repeat (3) tick();
    end
    exp_cnt = CNT_EN ? 8'((N_LOSS > 255) ? 255 : N_LOSS) : 8'd0;
    checks++; if (lock_loss_count !== exp_cnt) begin failures++; $display("FAIL loss_cnt got=%0d exp=%0d", lock_loss_count, exp_cnt); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_lost got=%b exp=1", lock_lost); end
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    lockin_seq("lockin", 1'b0);
    test_strobes();
    test_lock_drop();
    lockin_seq("relock", 1'b1);
    test_reset_sys_up();
    test_settle_glitch();
    test_terminal_drop();
    test_reset_with_drop();
    test_loss_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
